// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronised rx, oversampled framing (5..8 data, optional parity, 1/2 stop), held-word handshake.
// Build option RX_MAJORITY_VOTE_EN: each bit is the majority of three samples centred on the bit middle.
module uart_rx_core #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       on_i,
   input  logic [1:0] frame_type_i,
   input  logic [1:0] parity_type_i,
   input  logic       stop_type_i,
   input  logic [3:0] baud_sel_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       rx_parity_err_o,
   output logic       rx_frame_err_o,
   output logic       rx_overrun_o,
   output logic       rx_busy_o
);
   localparam int unsigned TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

   function automatic logic [15:0] baud_div(input logic [3:0] sel);
      int unsigned baud;
      case (sel)
         4'd0:    baud = 200;
         4'd1:    baud = 300;
         4'd2:    baud = 600;
         4'd3:    baud = 1200;
         4'd4:    baud = 1800;
         4'd5:    baud = 2400;
         4'd6:    baud = 4800;
         4'd7:    baud = 9600;
         4'd8:    baud = 19200;
         4'd9:    baud = 28800;
         4'd10:   baud = 38400;
         4'd11:   baud = 57600;
         4'd12:   baud = 76800;
         4'd13:   baud = 115200;
         4'd14:   baud = 230400;
         default: baud = 460800;
      endcase
      return 16'((CLK_FREQ_HZ + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE));
   endfunction

   state_t          state_q;
   logic            rx_s1_q, rx_s2_q, rx_s3_q;
   logic [15:0]     div_q, div_cnt_q;
   logic [TW-1:0]   tick_cnt_q;
   logic [2:0]      bit_cnt_q, nbits_m1_q;
   logic [1:0]      ptype_q;
   logic            stop2_q;
   logic [7:0]      shreg_q;
   logic            perr_acc_q, ferr_acc_q, done_q;
   logic [7:0]      rx_data_q;
   logic            rx_valid_q, rx_perr_q, rx_ferr_q, rx_overrun_q;
   logic            tick, samp_en, bit_val, par_en;

   assign tick   = (div_cnt_q == div_q - 16'd1);
   assign par_en = ptype_q[0] ^ ptype_q[1];

`ifdef RX_MAJORITY_VOTE_EN
   logic [1:0] vote_q;

   // Decision lands on the third sample; the two earlier ones are kept in vote_q.
   assign samp_en = tick && (tick_cnt_q == TW'(OVERSAMPLE/2));
   assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s2_q) | (vote_q[1] & rx_s2_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vote_q <= 2'b11;
      end else if (tick && tick_cnt_q == TW'(OVERSAMPLE/2-2)) begin
         vote_q[0] <= rx_s2_q;
      end else if (tick && tick_cnt_q == TW'(OVERSAMPLE/2-1)) begin
         vote_q[1] <= rx_s2_q;
      end
   end
`else
   assign samp_en = tick && (tick_cnt_q == TW'(OVERSAMPLE/2-1));
   assign bit_val = rx_s2_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_s3_q      <= 1'b1;
         div_q        <= 16'd1;
         div_cnt_q    <= 16'd0;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= 3'd0;
         nbits_m1_q   <= 3'd7;
         ptype_q      <= 2'b00;
         stop2_q      <= 1'b0;
         shreg_q      <= 8'd0;
         perr_acc_q   <= 1'b0;
         ferr_acc_q   <= 1'b0;
         done_q       <= 1'b0;
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         rx_perr_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         rx_s1_q      <= rx_i;
         rx_s2_q      <= rx_s1_q;
         rx_s3_q      <= rx_s2_q;
         done_q       <= 1'b0;
         rx_overrun_q <= 1'b0;

         // An accept in the completion cycle frees the slot, so the new word loads without overrun.
         if (done_q) begin
            if (!rx_valid_q || rx_ready_i) begin
               rx_data_q  <= shreg_q;
               rx_perr_q  <= perr_acc_q;
               rx_ferr_q  <= ferr_acc_q;
               rx_valid_q <= 1'b1;
            end else begin
               rx_overrun_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_q <= 1'b0;
         end

         if (state_q != S_IDLE) begin
            div_cnt_q <= tick ? 16'd0 : div_cnt_q + 16'd1;
            if (tick) tick_cnt_q <= (tick_cnt_q == TW'(OVERSAMPLE-1)) ? '0 : tick_cnt_q + TW'(1);
         end

         case (state_q)
            S_IDLE: begin
               // Edge detection means a break must see rx high again before re-arming.
               if (on_i && rx_s3_q && !rx_s2_q) begin
                  state_q    <= S_START;
                  div_cnt_q  <= 16'd0;
                  tick_cnt_q <= '0;
                  div_q      <= baud_div(baud_sel_i);
                  nbits_m1_q <= 3'(frame_type_i) + 3'd4;
                  ptype_q    <= parity_type_i;
                  stop2_q    <= stop_type_i;
                  bit_cnt_q  <= 3'd0;
                  shreg_q    <= 8'd0;
                  perr_acc_q <= 1'b0;
                  ferr_acc_q <= 1'b0;
               end
            end
            S_START: if (samp_en) state_q <= bit_val ? S_IDLE : S_DATA;
            S_DATA: if (samp_en) begin
               shreg_q[bit_cnt_q] <= bit_val;
               bit_cnt_q          <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == nbits_m1_q) state_q <= par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (samp_en) begin
               perr_acc_q <= (^shreg_q ^ bit_val) != ptype_q[1];
               state_q    <= S_STOP1;
            end
            S_STOP1: if (samp_en) begin
               ferr_acc_q <= !bit_val;
               if (stop2_q) begin
                  state_q <= S_STOP2;
               end else begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            S_STOP2: if (samp_en) begin
               ferr_acc_q <= ferr_acc_q | !bit_val;
               state_q    <= S_IDLE;
               done_q     <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase

         if (state_q != S_IDLE && !on_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
         end
      end
   end

   assign rx_data_o       = rx_data_q;
   assign rx_valid_o      = rx_valid_q;
   assign rx_parity_err_o = rx_perr_q;
   assign rx_frame_err_o  = rx_ferr_q;
   assign rx_overrun_o    = rx_overrun_q;
   assign rx_busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame-level model queue checked every cycle plus literal per-test expectations.
`timescale 1ns/1ps
module tb_uart_rx_core;
   logic       clk = 1'b0, rst = 1'b1, on = 1'b0, stop_type = 1'b0, rx = 1'b1, rx_ready = 1'b0;
   logic [1:0] frame_type = 2'b11, parity_type = 2'b00;
   logic [3:0] baud_sel = 4'd15;
   logic [7:0] rx_data;
   logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

   int vectors = 0, miscompares = 0, ovr_seen = 0, exp_ovr = 0, ovr_base = 0;
   logic [9:0] exp_q[$];   // {parity_err, frame_err, data}
   int baud_tab[16] = '{200, 300, 600, 1200, 1800, 2400, 4800, 9600, 19200, 28800,
                        38400, 57600, 76800, 115200, 230400, 460800};

   always #5 clk = ~clk;

   uart_rx_core #(.CLK_FREQ_HZ(100_000_000), .OVERSAMPLE(16)) dut (
      .clk_i(clk), .rst_i(rst), .on_i(on), .frame_type_i(frame_type),
      .parity_type_i(parity_type), .stop_type_i(stop_type), .baud_sel_i(baud_sel),
      .rx_i(rx), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .rx_parity_err_o(rx_parity_err), .rx_frame_err_o(rx_frame_err),
      .rx_overrun_o(rx_overrun), .rx_busy_o(rx_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int div_of(input logic [3:0] s);
      return $rtoi(100.0e6 / (real'(baud_tab[s]) * 16.0) + 0.5);
   endfunction

   task automatic model_push(input logic [7:0] d, input logic pe, input logic fe);
      if (exp_q.size() != 0) exp_ovr++;
      else exp_q.push_back({pe, fe, d});
   endtask

   // Every cycle a word is presented it must match the oldest word the model delivered.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_overrun) ovr_seen++;
         if (rx_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL model_valid: rx_valid=1 data=%0h but model holds no word at %0t", rx_data, $time);
            end else begin
               check("model_data", 32'(rx_data), 32'(exp_q[0][7:0]));
               check("model_perr", 32'(rx_parity_err), 32'(exp_q[0][9]));
               check("model_ferr", 32'(rx_frame_err), 32'(exp_q[0][8]));
               if (rx_ready) exp_q.delete(0);
            end
         end
      end
   end

   task automatic cfg(input logic [1:0] ft, input logic [1:0] pt, input logic st, input logic [3:0] bs);
      @(negedge clk);
      frame_type = ft; parity_type = pt; stop_type = st; baud_sel = bs;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop_low);
      int nb, bitc;
      logic [7:0] dm;
      logic p, pen;
      nb   = int'(frame_type) + 5;
      dm   = d & (8'hFF >> (8 - nb));
      bitc = 16 * div_of(baud_sel);
      pen  = (parity_type == 2'b01) || (parity_type == 2'b10);
      p    = (^dm) ^ (parity_type == 2'b10) ^ flip_par;
      rx = 1'b0; repeat (bitc) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         rx = d[i]; repeat (bitc) @(negedge clk);
      end
      if (pen) begin
         rx = p; repeat (bitc) @(negedge clk);
      end
      model_push(dm, pen && flip_par, stop_low);
      rx = !stop_low; repeat (bitc) @(negedge clk);
      if (stop_type) begin
         rx = 1'b1; repeat (bitc) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic accept(input string name, input logic [7:0] d, input logic pe, input logic fe);
      int n = 0;
      while (!rx_valid && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_valid: rx_valid still 0 after 4000 cycles, required 1", name);
      end
      check({name, "_data"}, 32'(rx_data), 32'(d));
      check({name, "_perr"}, 32'(rx_parity_err), 32'(pe));
      check({name, "_ferr"}, 32'(rx_frame_err), 32'(fe));
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
      @(negedge clk);
      check({name, "_cleared"}, 32'(rx_valid), 32'(0));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(rx_valid), 32'(0));
      check("rst_data", 32'(rx_data), 32'(0));
      check("rst_perr", 32'(rx_parity_err), 32'(0));
      check("rst_ferr", 32'(rx_frame_err), 32'(0));
      check("rst_overrun", 32'(rx_overrun), 32'(0));
      check("rst_busy", 32'(rx_busy), 32'(0));
      @(posedge clk); #1 rst = 1'b0; on = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 basic frame
      cfg(2'b11, 2'b00, 1'b0, 4'd15);
      send_frame(8'hA5, 1'b0, 1'b0);
      check("8n1_busy_after_stop", 32'(rx_busy), 32'(0));
      accept("8n1_a5", 8'hA5, 1'b0, 1'b0);

      // 5 bits, even parity, 2 stop bits; good then flipped parity
      cfg(2'b00, 2'b01, 1'b1, 4'd15);
      send_frame(8'h13, 1'b0, 1'b0);
      accept("5e2_ok", 8'h13, 1'b0, 1'b0);
      send_frame(8'h13, 1'b1, 1'b0);
      accept("5e2_bad", 8'h13, 1'b1, 1'b0);

      // Stop bit low, then re-arm
      cfg(2'b11, 2'b00, 1'b0, 4'd15);
      send_frame(8'h3C, 1'b0, 1'b1);
      accept("stop_low", 8'h3C, 1'b0, 1'b1);
      repeat (600) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0);
      accept("rearm", 8'h5A, 1'b0, 1'b0);

      // Glitch of 4 ticks: false start, no word
      rx = 1'b0; repeat (20) @(negedge clk);
      check("glitch_busy_hi", 32'(rx_busy), 32'(1));
      repeat (36) @(negedge clk);
      rx = 1'b1; repeat (100) @(negedge clk);
      check("glitch_busy_lo", 32'(rx_busy), 32'(0));
      check("glitch_no_valid", 32'(rx_valid), 32'(0));

      // Back-to-back frames with consumer stalled
      ovr_base = ovr_seen;
      send_frame(8'h11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0);
      repeat (300) @(negedge clk);
      check("ovr_pulses", 32'(ovr_seen - ovr_base), 32'(1));
      accept("ovr_held", 8'h11, 1'b0, 1'b0);

      // Receiver disabled mid-data, then a clean frame
      rx = 1'b0; repeat (224) @(negedge clk);
      rx = 1'b1; repeat (224) @(negedge clk);
      rx = 1'b0; repeat (100) @(negedge clk);
      on = 1'b0; repeat (124) @(negedge clk);
      rx = 1'b1;
      check("off_busy", 32'(rx_busy), 32'(0));
      repeat (2000) @(negedge clk);
      check("off_no_valid", 32'(rx_valid), 32'(0));
      on = 1'b1; repeat (10) @(negedge clk);
      send_frame(8'h7E, 1'b0, 1'b0);
      accept("after_off", 8'h7E, 1'b0, 1'b0);

      // 7 bits odd parity at 230400 (DIV 27); upper bit of stimulus ignored
      cfg(2'b10, 2'b10, 1'b0, 4'd14);
      send_frame(8'hD5, 1'b0, 1'b0);
      accept("7o1", 8'h55, 1'b0, 1'b0);

      // 6 bits even parity at 115200 (DIV 54)
      cfg(2'b01, 2'b01, 1'b0, 4'd13);
      send_frame(8'hEB, 1'b0, 1'b0);
      accept("6e1", 8'h2B, 1'b0, 1'b0);

      // Break: line low for 12 bit times
      cfg(2'b11, 2'b00, 1'b0, 4'd15);
      rx = 1'b0; repeat (9 * 224) @(negedge clk);
      model_push(8'h00, 1'b0, 1'b1);
      repeat (3 * 224) @(negedge clk);
      rx = 1'b1;
      accept("break", 8'h00, 1'b0, 1'b1);
      repeat (224) @(negedge clk);
      send_frame(8'hC3, 1'b0, 1'b0);
      accept("after_break", 8'hC3, 1'b0, 1'b0);

      // Reset mid-frame while a word is held
      send_frame(8'h99, 1'b0, 1'b0);
      rx = 1'b0; repeat (3 * 224) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      exp_q.delete();
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", 32'(rx_valid), 32'(0));
      check("rst_mid_busy", 32'(rx_busy), 32'(0));
      check("rst_mid_data", 32'(rx_data), 32'(0));
      repeat (2 * 224) @(negedge clk);
      send_frame(8'h66, 1'b0, 1'b0);
      accept("after_rst", 8'h66, 1'b0, 1'b0);

      check("overrun_total", 32'(ovr_seen), 32'(exp_ovr));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
